// File: rtl/bridge_initiator_if.sv
// Command, response and bridge-side bus signals of the bridge initiator.
// The slave modport is the initiator's view; master is the driver/bridge view.
interface bridge_initiator_if #(
  parameter int DATA_W = 32
) ();
  logic              io_cmd_valid;
  logic              io_cmd_ready;
  logic              io_cmd_write;
  logic [DATA_W-1:0] io_cmd_addr;
  logic [DATA_W-1:0] io_cmd_wdata;
  logic              io_rsp_valid;
  logic              io_rsp_ready;
  logic [DATA_W-1:0] io_rsp_data;
  logic              io_rsp_err;
  logic [DATA_W-1:0] io_bus_address;
  logic              io_bus_write;
  logic [DATA_W-1:0] io_bus_in_data;
  logic [DATA_W-1:0] io_bus_out_data;

  modport slave (
    input  io_cmd_valid,
    output io_cmd_ready,
    input  io_cmd_write,
    input  io_cmd_addr,
    input  io_cmd_wdata,
    output io_rsp_valid,
    input  io_rsp_ready,
    output io_rsp_data,
    output io_rsp_err,
    output io_bus_address,
    output io_bus_write,
    output io_bus_in_data,
    input  io_bus_out_data
  );

  modport master (
    output io_cmd_valid,
    input  io_cmd_ready,
    output io_cmd_write,
    output io_cmd_addr,
    output io_cmd_wdata,
    input  io_rsp_valid,
    output io_rsp_ready,
    input  io_rsp_data,
    input  io_rsp_err,
    input  io_bus_address,
    input  io_bus_write,
    input  io_bus_in_data,
    output io_bus_out_data
  );
endinterface

// File: rtl/bridge_initiator.sv
// Single-outstanding bus initiator: one command in, one bus cycle, one response out.
// Misaligned or unmapped addresses are answered with an error and never reach the bus.
module bridge_initiator #(
  parameter int DATA_W       = 32,
  parameter int NUM_SLOTS    = 2,
  parameter int READ_LATENCY = 0,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  bridge_initiator_if.slave port,
  output logic [CNT_W-1:0] io_txn_count
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    WAIT,
    RESP
  } state_t;

  localparam logic [DATA_W-1:0] LIMIT = DATA_W'(4 * NUM_SLOTS);
  localparam logic [3:0]        RL    = 4'(READ_LATENCY);

  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic [3:0]        cnt;
  logic              accept;
  logic              addr_ok;
  logic              sample;
  logic              rsp_fire;

  assign addr_ok = (port.io_cmd_addr[1:0] == 2'b00) &&
                   (port.io_cmd_addr < LIMIT);
  assign accept   = port.io_cmd_valid && (state == IDLE);
  assign rsp_fire = (state == RESP) && port.io_rsp_ready;

  // Read data is captured on the final cycle the address is on the bus.
  assign sample = ((state == BUS) && (RL == 4'd0)) ||
                  ((state == WAIT) && (cnt == RL));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = addr_ok ? BUS : RESP;
      end
      BUS: begin
        state_nx = (RL == 4'd0) ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt == RL) state_nx = RESP;
      end
      RESP: begin
        if (port.io_rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    port.io_cmd_ready   = 1'b0;
    port.io_rsp_valid   = 1'b0;
    port.io_rsp_data    = '0;
    port.io_rsp_err     = 1'b0;
    port.io_bus_address = '0;
    port.io_bus_write   = 1'b0;
    port.io_bus_in_data = '0;
    unique case (state)
      IDLE: port.io_cmd_ready = 1'b1;
      BUS: begin
        port.io_bus_address = addr_q;
        port.io_bus_write   = write_q;
        port.io_bus_in_data = write_q ? wdata_q : '0;
      end
      WAIT: port.io_bus_address = addr_q;
      RESP: begin
        port.io_rsp_valid = 1'b1;
        port.io_rsp_data  = rdata_q;
        port.io_rsp_err   = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt     <= '0;
    end else begin
      if (accept) begin
        addr_q  <= port.io_cmd_addr;
        wdata_q <= port.io_cmd_wdata;
        write_q <= port.io_cmd_write;
        err_q   <= !addr_ok;
        rdata_q <= '0;
      end
      if (state == BUS)       cnt <= 4'd1;
      else if (state == WAIT) cnt <= cnt + 4'd1;
      if (sample && !write_q) rdata_q <= port.io_bus_out_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)         io_txn_count <= '0;
    else if (rsp_fire) io_txn_count <= io_txn_count + 1'b1;
  end

endmodule

// File: tb/tb_bridge_initiator.sv
// Directed bench: dut0 has zero read latency and a 16-bit counter,
// dut3 has READ_LATENCY=3 and a 4-bit counter so the wrap is reachable.
module tb_bridge_initiator;

  logic clk = 1'b0;
  logic rst0;
  logic rst3;
  always #5 clk = ~clk;

  bridge_initiator_if #(.DATA_W(32)) if0 ();
  bridge_initiator_if #(.DATA_W(32)) if3 ();

  logic [15:0] cnt0;
  logic [3:0]  cnt3;

  bridge_initiator #(
    .DATA_W(32), .NUM_SLOTS(2), .READ_LATENCY(0), .CNT_W(16)
  ) dut0 (
    .clk(clk), .reset(rst0), .port(if0.slave), .io_txn_count(cnt0)
  );

  bridge_initiator #(
    .DATA_W(32), .NUM_SLOTS(2), .READ_LATENCY(3), .CNT_W(4)
  ) dut3 (
    .clk(clk), .reset(rst3), .port(if3.slave), .io_txn_count(cnt3)
  );

  // Bridge models: two words, combinational read.
  logic [31:0] mem0 [2];
  logic [31:0] mem3 [2];
  int pulses0 = 0;
  int pulses3 = 0;

  always @(posedge clk) begin
    if (rst0) begin
      mem0[0] <= 32'h0;
      mem0[1] <= 32'h539;
    end else if (if0.io_bus_write) begin
      mem0[if0.io_bus_address[2]] <= if0.io_bus_in_data;
    end
    if (if0.io_bus_write) pulses0++;
  end

  always @(posedge clk) begin
    if (rst3) begin
      mem3[0] <= 32'h0;
      mem3[1] <= 32'h539;
    end else if (if3.io_bus_write) begin
      mem3[if3.io_bus_address[2]] <= if3.io_bus_in_data;
    end
    if (if3.io_bus_write) pulses3++;
  end

  assign if0.io_bus_out_data = mem0[if0.io_bus_address[2]];
  assign if3.io_bus_out_data = mem3[if3.io_bus_address[2]];

  int checks   = 0;
  int failures = 0;
  int exp_cnt0 = 0;
  int exp_cnt3 = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] data;
    logic        err;
    int          lat;
  } vec_t;

  task automatic txn0(input vec_t v, input string tag);
    int lat;
    int p;
    @(negedge clk);
    if0.io_cmd_valid = 1'b1;
    if0.io_cmd_write = v.wr;
    if0.io_cmd_addr  = v.addr;
    if0.io_cmd_wdata = v.wdata;
    chk({tag, ".cmd_ready"}, 32'(if0.io_cmd_ready), 32'd1);
    p = pulses0;
    @(posedge clk);
    @(negedge clk);
    if0.io_cmd_valid = 1'b0;
    lat = 1;
    while (!if0.io_rsp_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(v.lat));
    chk({tag, ".data"}, if0.io_rsp_data, v.data);
    chk({tag, ".err"}, 32'(if0.io_rsp_err), 32'(v.err));
    if0.io_rsp_ready = 1'b1;
    @(posedge clk);
    exp_cnt0++;
    @(negedge clk);
    if0.io_rsp_ready = 1'b0;
    chk({tag, ".pulses"}, 32'(pulses0 - p), 32'(v.wr && !v.err));
    chk({tag, ".count"}, 32'(cnt0), 32'(exp_cnt0 % 65536));
  endtask

  task automatic txn3(input vec_t v, input string tag);
    int lat;
    int held;
    int p;
    @(negedge clk);
    if3.io_cmd_valid = 1'b1;
    if3.io_cmd_write = v.wr;
    if3.io_cmd_addr  = v.addr;
    if3.io_cmd_wdata = v.wdata;
    p = pulses3;
    @(posedge clk);
    @(negedge clk);
    if3.io_cmd_valid = 1'b0;
    lat  = 1;
    held = 0;
    while (!if3.io_rsp_valid && lat < 30) begin
      if (if3.io_bus_address == v.addr) held++;
      @(negedge clk);
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(v.lat));
    chk({tag, ".data"}, if3.io_rsp_data, v.data);
    chk({tag, ".err"}, 32'(if3.io_rsp_err), 32'(v.err));
    if (!v.err) chk({tag, ".held"}, 32'(held), 32'd4);
    if3.io_rsp_ready = 1'b1;
    @(posedge clk);
    exp_cnt3++;
    @(negedge clk);
    if3.io_rsp_ready = 1'b0;
    chk({tag, ".pulses"}, 32'(pulses3 - p), 32'(v.wr && !v.err));
    chk({tag, ".count"}, 32'(cnt3), 32'(exp_cnt3 % 16));
  endtask

  vec_t vecs [9];
  vec_t v;

  initial begin
    vecs[0] = '{1'b1, 32'h0,        32'hDEADBEEF, 32'h0,        1'b0, 2};
    vecs[1] = '{1'b0, 32'h0,        32'h0,        32'hDEADBEEF, 1'b0, 2};
    vecs[2] = '{1'b0, 32'h4,        32'h0,        32'h00000539, 1'b0, 2};
    vecs[3] = '{1'b0, 32'h2,        32'h0,        32'h0,        1'b1, 1};
    vecs[4] = '{1'b0, 32'h8,        32'h0,        32'h0,        1'b1, 1};
    vecs[5] = '{1'b1, 32'h4,        32'h12345678, 32'h0,        1'b0, 2};
    vecs[6] = '{1'b0, 32'h4,        32'h0,        32'h12345678, 1'b0, 2};
    vecs[7] = '{1'b1, 32'h3,        32'hCAFEF00D, 32'h0,        1'b1, 1};
    vecs[8] = '{1'b0, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b1, 1};

    rst0 = 1'b1;
    rst3 = 1'b1;
    if0.io_cmd_valid = 1'b0;
    if0.io_cmd_write = 1'b0;
    if0.io_cmd_addr  = '0;
    if0.io_cmd_wdata = '0;
    if0.io_rsp_ready = 1'b0;
    if3.io_cmd_valid = 1'b0;
    if3.io_cmd_write = 1'b0;
    if3.io_cmd_addr  = '0;
    if3.io_cmd_wdata = '0;
    if3.io_rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.cmd_ready", 32'(if0.io_cmd_ready), 32'd1);
    chk("rst.rsp_valid", 32'(if0.io_rsp_valid), 32'd0);
    chk("rst.rsp_data", if0.io_rsp_data, 32'd0);
    chk("rst.rsp_err", 32'(if0.io_rsp_err), 32'd0);
    chk("rst.bus_addr", if0.io_bus_address, 32'd0);
    chk("rst.bus_write", 32'(if0.io_bus_write), 32'd0);
    chk("rst.bus_in", if0.io_bus_in_data, 32'd0);
    chk("rst.count", 32'(cnt0), 32'd0);
    rst0 = 1'b0;
    rst3 = 1'b0;

    for (int i = 0; i < 9; i++) txn0(vecs[i], $sformatf("v%0d", i));

    // Response backpressure with a new command held on the port.
    @(negedge clk);
    if0.io_cmd_valid = 1'b1;
    if0.io_cmd_write = 1'b0;
    if0.io_cmd_addr  = 32'h0;
    @(posedge clk);
    @(negedge clk);
    if0.io_cmd_addr = 32'h8;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d.valid", k), 32'(if0.io_rsp_valid), 32'd1);
      chk($sformatf("bp%0d.data", k), if0.io_rsp_data, 32'hDEADBEEF);
      chk($sformatf("bp%0d.err", k), 32'(if0.io_rsp_err), 32'd0);
      chk($sformatf("bp%0d.ready", k), 32'(if0.io_cmd_ready), 32'd0);
      @(negedge clk);
    end
    if0.io_cmd_valid = 1'b0;
    if0.io_rsp_ready = 1'b1;
    @(posedge clk);
    exp_cnt0++;
    @(negedge clk);
    if0.io_rsp_ready = 1'b0;
    chk("bp.count", 32'(cnt0), 32'(exp_cnt0));
    chk("bp.idle", 32'(if0.io_cmd_ready), 32'd1);
    chk("bp.valid_lo", 32'(if0.io_rsp_valid), 32'd0);

    // Reset asserted during the bus cycle of a read.
    @(negedge clk);
    if0.io_cmd_valid = 1'b1;
    if0.io_cmd_addr  = 32'h4;
    @(posedge clk);
    @(negedge clk);
    if0.io_cmd_valid = 1'b0;
    chk("mid.bus_addr", if0.io_bus_address, 32'h4);
    rst0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst0 = 1'b0;
    exp_cnt0 = 0;
    chk("mid.cmd_ready", 32'(if0.io_cmd_ready), 32'd1);
    chk("mid.rsp_valid", 32'(if0.io_rsp_valid), 32'd0);
    chk("mid.count", 32'(cnt0), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("mid.no_rsp", 32'(if0.io_rsp_valid), 32'd0);
    end
    v = '{1'b0, 32'h4, 32'h0, 32'h539, 1'b0, 2};
    txn0(v, "post");

    // Read latency 3 and counter wrap on the narrow counter.
    v = '{1'b0, 32'h4, 32'h0, 32'h539, 1'b0, 5};
    txn3(v, "rl3.rd");
    v = '{1'b1, 32'h0, 32'h0000BEEF, 32'h0, 1'b0, 5};
    txn3(v, "rl3.wr");
    v = '{1'b0, 32'h0, 32'h0, 32'h0000BEEF, 1'b0, 5};
    txn3(v, "rl3.rb");
    v = '{1'b0, 32'h1, 32'h0, 32'h0, 1'b1, 1};
    while (exp_cnt3 < 16) txn3(v, $sformatf("wrap%0d", exp_cnt3));
    chk("wrap.zero", 32'(cnt3), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
